// File: rtl/bash_hash_mc_regmap.sv
// -----------------------------------------------------------------------------
// bash_hash_mc_regmap
//   Multi-channel register map and job scheduler. It sits between the BRAM-style
//   port of axi4_lite_slave_ctrl and one shared bash_hash_cu/bash_hash pair.
//   Each of NCH channels has its own context: L, X block, Y result and status.
//   A channel queues one prep or start command. The shared core is granted
//   round-robin. The granted channel's X/L are muxed to the core, and Y is
//   captured back into that channel when the core reports completion.
//
// Ports
//   clk_i, rst_i    clock; asynchronous active-high reset
//   en_i, we_i      bus access enable; byte write strobes (all zero = read)
//   addr_i          byte address: channel at [CH_SHIFT +: log2(NCH)],
//                   word offset at [CH_SHIFT-1:2]
//   wrdata_i        bus write data
//   rddata_o        registered read data (1-cycle latency, holds otherwise)
//   core_prep_o     1-cycle prep request to the core
//   core_start_o    1-cycle start request to the core
//   core_active_i   core busy (not needed by the scheduler)
//   core_rdy_i      core done pulse; y_i is valid in the same cycle
//   x_o, l_o        X block and L of the granted channel
//   y_i             core result
//   ch_o            granted channel index
//
// Word map per channel: 0 CTRL, 1 STATUS, 2 L, 16.. X, 48.. Y (read-only)
// -----------------------------------------------------------------------------
module bash_hash_mc_regmap #(
  parameter int XLEN     = 32,
  parameter int ADDRLEN  = 16,
  parameter int NCH      = 2,
  parameter int XWORDS   = 32,
  parameter int YWORDS   = 16,
  parameter int CH_SHIFT = 8,
  localparam int CHW     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     en_i,
  input  logic [XLEN/8-1:0]        we_i,
  input  logic [ADDRLEN-1:0]       addr_i,
  input  logic [XLEN-1:0]          wrdata_i,
  output logic [XLEN-1:0]          rddata_o,
  output logic                     core_prep_o,
  output logic                     core_start_o,
  input  logic                     core_active_i,
  input  logic                     core_rdy_i,
  output logic [XLEN*XWORDS-1:0]   x_o,
  output logic [XLEN-1:0]          l_o,
  input  logic [XLEN*YWORDS-1:0]   y_i,
  output logic [CHW-1:0]           ch_o
);

  localparam int X_BASE = 16;
  localparam int Y_BASE = 48;
  localparam int XIW    = $clog2(XWORDS);
  localparam int YIW    = $clog2(YWORDS);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t          r_state, w_state_nxt;
  logic [XLEN-1:0] r_l [NCH];
  logic [XLEN-1:0] r_x [NCH][XWORDS];
  logic [XLEN-1:0] r_y [NCH][YWORDS];
  logic [3:0]      r_cmd [NCH];
  logic [NCH-1:0]  r_pend, r_done, r_err;
  logic [CHW-1:0]  r_gnt, r_last;
  logic [XLEN-1:0] r_rddata;

  // Scheduling does not depend on core_active_i, and the address bits outside
  // the channel/word fields carry no meaning.
  logic w_unused;
  assign w_unused = ^{core_active_i, addr_i[1:0], addr_i[ADDRLEN-1:CH_SHIFT+CHW]};

  // ---------------------------------------------------------------- decode
  logic [CHW-1:0] w_ch;
  logic [31:0]    w_wi;
  logic [XIW-1:0] w_xi;
  logic [YIW-1:0] w_yi;
  logic           w_hit_ctrl, w_hit_status, w_hit_l, w_hit_x, w_hit_y;
  logic           w_wr;
  logic [1:0]     w_cmd;

  assign w_ch         = addr_i[CH_SHIFT +: CHW] & CHW'(NCH - 1);
  assign w_wi         = 32'(addr_i[CH_SHIFT-1:2]);
  assign w_xi         = XIW'(w_wi - X_BASE);
  assign w_yi         = YIW'(w_wi - Y_BASE);
  assign w_hit_ctrl   = (w_wi == 0);
  assign w_hit_status = (w_wi == 1);
  assign w_hit_l      = (w_wi == 2);
  assign w_hit_x      = (w_wi >= X_BASE) && (w_wi < X_BASE + XWORDS);
  assign w_hit_y      = (w_wi >= Y_BASE) && (w_wi < Y_BASE + YWORDS);
  assign w_wr         = en_i && (we_i != '0);
  assign w_cmd        = we_i[0] ? wrdata_i[1:0] : 2'b00;

  // A channel is busy while its command is queued or while it owns the core.
  // The channel picked this cycle is still pending, so a bus write landing on
  // it in the same cycle is treated as a write to a busy channel.
  logic [NCH-1:0] w_busy;
  logic           w_ch_busy;
  always_comb begin
    for (int c = 0; c < NCH; c++)
      w_busy[c] = r_pend[c] | ((r_state != S_IDLE) && (r_gnt == CHW'(c)));
  end
  assign w_ch_busy = w_busy[w_ch];

  // Round-robin pick: the loop walks from the farthest candidate to the
  // nearest one after r_last, so the nearest pending channel is kept.
  logic [CHW-1:0] w_pick;
  logic           w_any;
  assign w_any = |r_pend;
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    logic [CHW-1:0] idx;
    idx    = '0;
    w_pick = r_last;
    for (int i = NCH; i >= 1; i--) begin
      idx = CHW'((int'(r_last) + i) % NCH);
      if (r_pend[idx]) w_pick = idx;
    end
  end

  // ------------------------------------------------------------------ FSM
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: sequential state uses non-blocking (<=) assignments only.
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_any) w_state_nxt = S_ISSUE;
      S_ISSUE: w_state_nxt = core_rdy_i ? S_IDLE : S_WAIT;
      S_WAIT:  if (core_rdy_i) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    core_prep_o  = 1'b0;
    core_start_o = 1'b0;
    if (r_state == S_ISSUE) begin
      core_prep_o  = r_cmd[r_gnt][0];
      core_start_o = r_cmd[r_gnt][1];
    end
    l_o = r_l[r_gnt];
    for (int i = 0; i < XWORDS; i++) x_o[i*XLEN +: XLEN] = r_x[r_gnt][i];
  end

  assign ch_o     = r_gnt;
  assign rddata_o = r_rddata;

  // ------------------------------------------------------------ read mux
  logic [XLEN-1:0] w_rd;
  always_comb begin
    w_rd = '0;
    if (w_hit_status)
      w_rd[7:0] = {r_cmd[w_ch], 1'b0, r_err[w_ch], r_done[w_ch], w_busy[w_ch]};
    else if (w_hit_l) w_rd = r_l[w_ch];
    else if (w_hit_x) w_rd = r_x[w_ch][w_xi];
    else if (w_hit_y) w_rd = r_y[w_ch][w_yi];
  end

  // ------------------------------------------------------- context storage
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      // NOTE: the register file is reset, because all context must read back
      // as zero after reset; that keeps it in flops instead of block RAM.
      for (int c = 0; c < NCH; c++) begin
        r_l[c]   <= '0;
        r_cmd[c] <= '0;
        for (int i = 0; i < XWORDS; i++) r_x[c][i] <= '0;
        for (int i = 0; i < YWORDS; i++) r_y[c][i] <= '0;
      end
      r_pend   <= '0;
      r_done   <= '0;
      r_err    <= '0;
      r_gnt    <= '0;
      r_last   <= CHW'(NCH - 1);
      r_rddata <= '0;
    end else begin
      if ((r_state == S_IDLE) && w_any) begin
        r_gnt  <= w_pick;
        r_last <= w_pick;
      end
      if (r_state == S_ISSUE) r_pend[r_gnt] <= 1'b0;
      if ((r_state != S_IDLE) && core_rdy_i) begin
        for (int i = 0; i < YWORDS; i++) r_y[r_gnt][i] <= y_i[i*XLEN +: XLEN];
        r_done[r_gnt] <= 1'b1;
      end

      // The granted channel is always busy, so the bus writes below never
      // touch the same pend/done bit as the core-side updates above.
      if (w_wr) begin
        if (w_hit_ctrl) begin
          if (w_cmd != 2'b00) begin
            if (w_ch_busy || (w_cmd == 2'b11)) begin
              r_err[w_ch] <= 1'b1;
            end else begin
              r_pend[w_ch] <= 1'b1;
              r_done[w_ch] <= 1'b0;
              r_cmd[w_ch]  <= {2'b00, w_cmd};
            end
          end
        end else if (w_hit_status) begin
          if (we_i[0] && wrdata_i[2]) r_err[w_ch] <= 1'b0;
        end else if (w_hit_l || w_hit_x) begin
          if (w_ch_busy) begin
            r_err[w_ch] <= 1'b1;
          end else begin
            for (int b = 0; b < XLEN/8; b++) begin
              if (we_i[b]) begin
                if (w_hit_l) r_l[w_ch][b*8 +: 8]       <= wrdata_i[b*8 +: 8];
                else         r_x[w_ch][w_xi][b*8 +: 8] <= wrdata_i[b*8 +: 8];
              end
            end
          end
        end
      end

      if (en_i && (we_i == '0)) r_rddata <= w_rd;
    end
  end

endmodule
